test_mode_ctrl: RTL and testbench

//   Sequences test-mode changes for the chip-level mode decoder. Filters TEST[1:0], quiesces functional

---
 rtl/test_mode_pkg.sv | 45 ++++
 rtl/tmc_tst_filter.sv | 36 +++
 rtl/test_mode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_test_mode_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_mode_pkg.sv
// Shared encodings and defaults for the test-mode sequencer.
// Optional BIST watchdog is enabled in test_mode_ctrl by defining TMC_BIST_WDOG_EN.
package test_mode_pkg;

   typedef enum logic [1:0] {
      MODE_FUNC  = 2'b00,
      MODE_SCAN  = 2'b01,
      MODE_BIST  = 2'b10,
      MODE_ALIVE = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_ACTIVE   = 2'b00,
      ST_QUIESCE  = 2'b01,
      ST_GAP      = 2'b10,
      ST_BIST_RUN = 2'b11
   } state_e;

   typedef struct packed {
      logic alive;
      logic bist;
      logic scan;
      logic func;
   } mode_oh_t;

   localparam int DEF_STABLE_CYC  = 4;
   localparam int DEF_GAP_CYC     = 2;
   localparam int DEF_QTO_CYC     = 64;
   localparam int DEF_BIST_TO_CYC = 4096;
   localparam int DEF_CNT_W       = 13;

   function automatic mode_oh_t mode_decode(input mode_e m);
      mode_oh_t oh;
      oh = '0;
      case (m)
         MODE_FUNC:  oh.func  = 1'b1;
         MODE_SCAN:  oh.scan  = 1'b1;
         MODE_BIST:  oh.bist  = 1'b1;
         MODE_ALIVE: oh.alive = 1'b1;
         default:    oh       = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/tmc_tst_filter.sv
// TEST pin filter: registers TEST and reports when it has held one value
// for STABLE_CYC consecutive cycles.
module tmc_tst_filter
   import test_mode_pkg::*;
#(
   parameter int STABLE_CYC = DEF_STABLE_CYC
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] TEST,
   output logic [1:0] tst_q,
   output logic       stable
);

   localparam int SW = $clog2(STABLE_CYC + 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYC);

   logic [SW-1:0] cnt;

   // Count saturates so stable stays asserted while TEST holds.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         tst_q <= 2'b00;
         cnt   <= '0;
      end else begin
         tst_q <= TEST;
         if (TEST != tst_q)
            cnt <= '0;
         else if (cnt != STABLE_MAX)
            cnt <= cnt + SW'(1);
      end
   end

   assign stable = (cnt == STABLE_MAX);

endmodule

// File: rtl/test_mode_ctrl.sv
// Test-mode sequencer: filtered TEST request -> quiesce -> dead-band -> new one-hot mode,
// plus BIST start/done handshake. Define TMC_BIST_WDOG_EN to add the BIST watchdog.
module test_mode_ctrl
   import test_mode_pkg::*;
#(
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int QTO_CYC     = DEF_QTO_CYC,
`ifdef TMC_BIST_WDOG_EN
   parameter int BIST_TO_CYC = DEF_BIST_TO_CYC,
`endif
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] TEST,
   input  logic       QUIESCE_ACK,
   input  logic       BIST_DONE,
   input  logic       BIST_FAIL,
   output logic       FUNCMODE,
   output logic       SCANMODE,
   output logic       BISTMODE,
   output logic       ALIVE_EN,
   output logic [1:0] MODE_CUR,
   output logic       BUSY,
   output logic       QUIESCE_REQ,
   output logic       QUIESCE_TO,
   output logic       BIST_START,
   output logic       BIST_PASS,
   output logic       BIST_ERR,
   output logic       BIST_TIMEOUT
);

   localparam logic [CNT_W-1:0] QTO_LAST = CNT_W'(QTO_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
`ifdef TMC_BIST_WDOG_EN
   localparam logic [CNT_W-1:0] BIST_LAST = CNT_W'(BIST_TO_CYC - 1);
   logic bist_tmo;
`endif

   state_e           state;
   mode_e            mode_cur;
   mode_e            target;
   mode_oh_t         mode_oh;
   logic [CNT_W-1:0] cnt;
   logic             busy, qreq, qto, bstart, bpass, berr;

   logic [1:0] tst_q;
   logic       stable;
   logic       req;

   tmc_tst_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
      .CLK    (CLK),
      .RESET  (RESET),
      .TEST   (TEST),
      .tst_q  (tst_q),
      .stable (stable)
   );

   // Only ACTIVE consumes requests, so changes seen mid-sequence wait their turn.
   assign req = stable && (tst_q != mode_cur) && (state == ST_ACTIVE);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= ST_ACTIVE;
         mode_cur <= MODE_FUNC;
         target   <= MODE_FUNC;
         mode_oh  <= mode_decode(MODE_FUNC);
         cnt      <= '0;
         busy     <= 1'b0;
         qreq     <= 1'b0;
         qto      <= 1'b0;
         bstart   <= 1'b0;
         bpass    <= 1'b0;
         berr     <= 1'b0;
`ifdef TMC_BIST_WDOG_EN
         bist_tmo <= 1'b0;
`endif
      end else begin
         qto    <= 1'b0;
         bstart <= 1'b0;
         case (state)
            ST_ACTIVE: begin
               if (req) begin
                  target <= mode_e'(tst_q);
                  state  <= ST_QUIESCE;
                  qreq   <= 1'b1;
                  busy   <= 1'b1;
                  cnt    <= '0;
               end
            end
            ST_QUIESCE: begin
               // An ack in the final timeout cycle still counts as an ack.
               if (QUIESCE_ACK || (cnt == QTO_LAST)) begin
                  state   <= ST_GAP;
                  mode_oh <= '0;
                  cnt     <= '0;
                  qto     <= !QUIESCE_ACK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  mode_cur <= target;
                  mode_oh  <= mode_decode(target);
                  qreq     <= 1'b0;
                  cnt      <= '0;
                  if (target == MODE_BIST) begin
                     state    <= ST_BIST_RUN;
                     bstart   <= 1'b1;
                     bpass    <= 1'b0;
                     berr     <= 1'b0;
`ifdef TMC_BIST_WDOG_EN
                     bist_tmo <= 1'b0;
`endif
                  end else begin
                     state <= ST_ACTIVE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_BIST_RUN: begin
`ifdef TMC_BIST_WDOG_EN
               cnt <= cnt + CNT_W'(1);
`endif
               // bstart is high only in the first cycle, where DONE is ignored.
               if (!bstart && BIST_DONE) begin
                  bpass <= ~BIST_FAIL;
                  berr  <= BIST_FAIL;
                  state <= ST_ACTIVE;
                  busy  <= 1'b0;
               end
`ifdef TMC_BIST_WDOG_EN
               else if (cnt == BIST_LAST) begin
                  berr     <= 1'b1;
                  bist_tmo <= 1'b1;
                  state    <= ST_ACTIVE;
                  busy     <= 1'b0;
               end
`endif
            end
            default: state <= ST_ACTIVE;
         endcase
      end
   end

   assign FUNCMODE    = mode_oh.func;
   assign SCANMODE    = mode_oh.scan;
   assign BISTMODE    = mode_oh.bist;
   assign ALIVE_EN    = mode_oh.alive;
   assign MODE_CUR    = mode_cur;
   assign BUSY        = busy;
   assign QUIESCE_REQ = qreq;
   assign QUIESCE_TO  = qto;
   assign BIST_START  = bstart;
   assign BIST_PASS   = bpass;
   assign BIST_ERR    = berr;
`ifdef TMC_BIST_WDOG_EN
   assign BIST_TIMEOUT = bist_tmo;
`else
   assign BIST_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_test_mode_ctrl.sv
// Directed bench for test_mode_ctrl: expected values queued at stimulus time, popped at DUT output.
// Watchdog checks run when TMC_BIST_WDOG_EN is defined (BIST_TO_CYC=16).
module tb_test_mode_ctrl;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [1:0] TEST = 2'b00;
   logic       QUIESCE_ACK = 1'b0;
   logic       BIST_DONE = 1'b0;
   logic       BIST_FAIL = 1'b0;
   logic       FUNCMODE, SCANMODE, BISTMODE, ALIVE_EN;
   logic [1:0] MODE_CUR;
   logic       BUSY, QUIESCE_REQ, QUIESCE_TO, BIST_START;
   logic       BIST_PASS, BIST_ERR, BIST_TIMEOUT;

   test_mode_ctrl #(
`ifdef TMC_BIST_WDOG_EN
      .BIST_TO_CYC (16),
`endif
      .STABLE_CYC  (4),
      .GAP_CYC     (2),
      .QTO_CYC     (64),
      .CNT_W       (13)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .TEST         (TEST),
      .QUIESCE_ACK  (QUIESCE_ACK),
      .BIST_DONE    (BIST_DONE),
      .BIST_FAIL    (BIST_FAIL),
      .FUNCMODE     (FUNCMODE),
      .SCANMODE     (SCANMODE),
      .BISTMODE     (BISTMODE),
      .ALIVE_EN     (ALIVE_EN),
      .MODE_CUR     (MODE_CUR),
      .BUSY         (BUSY),
      .QUIESCE_REQ  (QUIESCE_REQ),
      .QUIESCE_TO   (QUIESCE_TO),
      .BIST_START   (BIST_START),
      .BIST_PASS    (BIST_PASS),
      .BIST_ERR     (BIST_ERR),
      .BIST_TIMEOUT (BIST_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t       sb[$];
   int         n_assert = 0;
   int         n_fail = 0;
   logic [1:0] cur_mode = 2'b00;

   // {FUNC,SCAN,BIST,ALIVE, MODE_CUR, BUSY,QREQ,QTO,START,PASS,ERR,TIMEOUT}
   localparam logic [12:0] V_RESET     = 13'b1000_00_0000000;
   localparam logic [12:0] V_QTO_GAP   = 13'b0000_01_1110000;
   localparam logic [12:0] V_BIST_GO   = 13'b0010_10_1001000;
   localparam logic [12:0] V_BIST_WAIT = 13'b0010_10_1000000;
   localparam logic [12:0] V_BIST_PASS = 13'b0010_10_0000100;
   localparam logic [12:0] V_BIST_FAIL = 13'b0010_10_0000010;
   localparam logic [12:0] V_ALIVE     = 13'b0001_11_0000010;
   localparam logic [12:0] V_BIST_TMO  = 13'b0010_10_0000011;

   function automatic logic [12:0] outs();
      return {FUNCMODE, SCANMODE, BISTMODE, ALIVE_EN, MODE_CUR, BUSY, QUIESCE_REQ,
              QUIESCE_TO, BIST_START, BIST_PASS, BIST_ERR, BIST_TIMEOUT};
   endfunction

   function automatic logic [3:0] mode_bits();
      return {FUNCMODE, SCANMODE, BISTMODE, ALIVE_EN};
   endfunction

   function automatic logic [3:0] oh(input logic [1:0] m);
      logic [3:0] r;
      r = 4'b1000 >> m;
      return r;
   endfunction

   function automatic logic cond(input int sel);
      case (sel)
         0:       return QUIESCE_REQ;
         1:       return QUIESCE_TO;
         2:       return !BUSY;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [15:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty observed=%0h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wait_sig(input int sel, input int maxc, output int n);
      n = 0;
      while (!cond(sel) && n < maxc) begin
         tick();
         n++;
      end
   endtask

   task automatic change_mode(input logic [1:0] tgt, input int exp_lat, input int ack_dly);
      int n;
      TEST = tgt;
      expect_val("req_latency", 16'(exp_lat));
      wait_sig(0, 100, n);
      chk(16'(n));
      expect_val("old_mode_hold", 16'({oh(cur_mode), 1'b1}));
      chk(16'({mode_bits(), BUSY}));
      repeat (ack_dly) tick();
      QUIESCE_ACK = 1'b1;
      tick();
      QUIESCE_ACK = 1'b0;
      expect_val("gap_entry", 16'(6'b0000_10));
      chk(16'({mode_bits(), QUIESCE_REQ, QUIESCE_TO}));
      expect_val("gap_cycles", 16'd2);
      n = 0;
      while (mode_bits() == 4'b0000 && n < 10) begin
         tick();
         n++;
      end
      chk(16'(n));
      expect_val("mode_cur", 16'(tgt));
      chk(16'(MODE_CUR));
      expect_val("new_mode_onehot", 16'(oh(tgt)));
      chk(16'(mode_bits()));
      cur_mode = tgt;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int bad;

      // reset held low three cycles
      repeat (3) tick();
      expect_val("reset_state", 16'(V_RESET));
      chk(16'(outs()));
      RESET = 1'b1;
      tick();
      expect_val("post_reset_idle", 16'(V_RESET));
      chk(16'(outs()));

      // short TEST glitches never satisfy the filter
      bad = 0;
      for (int r = 0; r < 6; r++) begin
         TEST = 2'b01;
         repeat (2) begin
            tick();
            if (BUSY || QUIESCE_REQ || !FUNCMODE) bad++;
         end
         TEST = 2'b00;
         repeat (2) begin
            tick();
            if (BUSY || QUIESCE_REQ || !FUNCMODE) bad++;
         end
      end
      expect_val("glitch_bad_cycles", 16'd0);
      chk(16'(bad));
      expect_val("glitch_final", 16'(V_RESET));
      chk(16'(outs()));

      // func -> scan with ack three cycles into quiesce
      change_mode(2'b01, 6, 3);
      expect_val("scan_state", 16'(13'b0100_01_0000000));
      chk(16'(outs()));

      // scan -> bist without ack: quiesce timeout path
      TEST = 2'b10;
      expect_val("bist_req_latency", 16'd6);
      wait_sig(0, 100, n);
      chk(16'(n));
      expect_val("scan_hold_in_quiesce", 16'(4'b0100));
      chk(16'(mode_bits()));
      expect_val("qto_cycles", 16'd64);
      wait_sig(1, 200, n);
      chk(16'(n));
      expect_val("qto_gap_state", 16'(V_QTO_GAP));
      chk(16'(outs()));
      tick();
      expect_val("qto_one_cycle", 16'd0);
      chk(16'(QUIESCE_TO));
      tick();
      expect_val("bist_start_state", 16'(V_BIST_GO));
      chk(16'(outs()));
      tick();
      expect_val("bist_start_one_cycle", 16'(V_BIST_WAIT));
      chk(16'(outs()));
      BIST_DONE = 1'b1;
      BIST_FAIL = 1'b0;
      tick();
      BIST_DONE = 1'b0;
      expect_val("bist_pass", 16'(V_BIST_PASS));
      chk(16'(outs()));
      cur_mode = 2'b10;

      // back to func, then bist again with TEST moving to alive mid-run
      change_mode(2'b00, 6, 1);
      change_mode(2'b10, 6, 0);
      TEST = 2'b11;
      bad = 0;
      repeat (10) begin
         tick();
         if (QUIESCE_REQ || !BISTMODE || !BUSY) bad++;
      end
      expect_val("deferred_in_bist", 16'd0);
      chk(16'(bad));
      BIST_DONE = 1'b1;
      BIST_FAIL = 1'b1;
      tick();
      BIST_DONE = 1'b0;
      BIST_FAIL = 1'b0;
      expect_val("bist_fail", 16'(V_BIST_FAIL));
      chk(16'(outs()));
      change_mode(2'b11, 1, 1);
      expect_val("alive_state", 16'(V_ALIVE));
      chk(16'(outs()));

      // bist run with no done
      change_mode(2'b10, 6, 1);
      expect_val("bist_restart_clears", 16'(V_BIST_GO));
      chk(16'(outs()));
`ifdef TMC_BIST_WDOG_EN
      expect_val("wdog_cycles", 16'd16);
      wait_sig(2, 100, n);
      chk(16'(n));
      expect_val("wdog_state", 16'(V_BIST_TMO));
      chk(16'(outs()));
`else
      repeat (40) tick();
      expect_val("bist_waits", 16'(V_BIST_WAIT));
      chk(16'(outs()));
      BIST_DONE = 1'b1;
      tick();
      BIST_DONE = 1'b0;
      expect_val("bist_late_pass", 16'(V_BIST_PASS));
      chk(16'(outs()));
`endif

      // reset asserted in the dead-band
      TEST = 2'b00;
      expect_val("gap_req_latency", 16'd6);
      wait_sig(0, 100, n);
      chk(16'(n));
      QUIESCE_ACK = 1'b1;
      tick();
      QUIESCE_ACK = 1'b0;
      expect_val("in_gap", 16'd0);
      chk(16'(mode_bits()));
      RESET = 1'b0;
      tick();
      expect_val("reset_in_gap", 16'(V_RESET));
      chk(16'(outs()));
      RESET = 1'b1;
      repeat (5) tick();
      expect_val("after_gap_reset", 16'(V_RESET));
      chk(16'(outs()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
